uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable character format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits) and gapless back-to-back framing. It sits between the PID telemetry logic and the board TX pin. Producers may queue up to FIFO_DEPTH characters without waiting for each frame to finish.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake of the UART transmitter: write strobe, character,
// and the FIFO status returned to the producer.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          i_TX_DV;
    logic [DATA_BITS-1:0]          i_TX_Byte;
    logic                          o_TX_Ready;
    logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count;

    // Producer (telemetry logic) side
    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Ready,
        input  o_FIFO_Count
    );

    // Transmitter side
    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Ready,
        output o_FIFO_Count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Configurable character format
// (5..9 data bits, none/even/odd parity, 1 or 2 stop bits). Frames are sent
// back-to-back with no idle gap while the FIFO holds characters.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             i_Clock,
    input  logic             i_Rst_n,
    uart_tx_fifo_if.slave    tx_if,
    output logic             o_TX_Active,
    output logic             o_TX_Serial,
    output logic             o_TX_Done
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 fifo_wr;
    logic                 fifo_pop;
    logic                 fifo_not_empty;
    logic [DATA_BITS-1:0] head_data;
    logic                 head_parity;

    // Ready comes from the registered count, so a pop in the same cycle
    // never opens a slot for a write while full.
    assign tx_if.o_TX_Ready   = (count_reg != CNT_FULL);
    assign tx_if.o_FIFO_Count = count_reg;
    assign fifo_wr            = tx_if.i_TX_DV && (count_reg != CNT_FULL);
    assign fifo_not_empty     = (count_reg != '0);
    assign head_data          = fifo_mem[rd_ptr_reg];
    assign head_parity        = (PARITY == 2) ? ~(^head_data) : (^head_data);

    // Character storage; contents need no reset because the count guards reads
    always_ff @(posedge i_Clock) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg] <= tx_if.i_TX_Byte;
        end
    end

    // Pointers wrap naturally modulo the power-of-two depth; count tracks occupancy
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM and datapath
    // ------------------------------------------------------------------
    state_t               state_reg,    state_next;
    logic [BAUD_W-1:0]    baud_reg,     baud_next;
    logic [IDX_W-1:0]     bit_idx_reg,  bit_idx_next;
    logic                 stop_idx_reg, stop_idx_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic                 parity_reg,   parity_next;
    logic                 serial_reg,   serial_next;
    logic                 active_reg,   active_next;
    logic                 done_reg,     done_next;
    logic                 bit_end;

    assign bit_end     = (baud_reg == BAUD_LAST);
    assign o_TX_Serial = serial_reg;
    assign o_TX_Active = active_reg;
    assign o_TX_Done   = done_reg;

    // State and datapath registers; reset drives the line high without a clock
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg    <= S_IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            serial_reg   <= 1'b1;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            serial_reg   <= serial_next;
            active_reg   <= active_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic; the line level is computed one cycle ahead so it is registered
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        serial_next   = serial_reg;
        active_next   = active_reg;
        done_next     = 1'b0;
        fifo_pop      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                serial_next = 1'b1;
                active_next = 1'b0;
                baud_next   = '0;
                if (fifo_not_empty) begin
                    fifo_pop    = 1'b1;
                    shift_next  = head_data;
                    parity_next = head_parity;
                    serial_next = 1'b0;
                    active_next = 1'b1;
                    state_next  = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    serial_next  = shift_reg[0];
                    state_next   = S_DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx_reg == IDX_LAST) begin
                        if (PARITY != 0) begin
                            serial_next = parity_reg;
                            state_next  = S_PARITY;
                        end else begin
                            serial_next   = 1'b1;
                            stop_idx_next = 1'b0;
                            state_next    = S_STOP;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                        serial_next  = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    baud_next     = '0;
                    serial_next   = 1'b1;
                    stop_idx_next = 1'b0;
                    state_next    = S_STOP;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (stop_idx_reg == STOP_LAST) begin
                        done_next = 1'b1;
                        if (fifo_not_empty) begin
                            // Gapless: the edge that ends the stop bit starts the next frame
                            fifo_pop    = 1'b1;
                            shift_next  = head_data;
                            parity_next = head_parity;
                            serial_next = 1'b0;
                            state_next  = S_START;
                        end else begin
                            serial_next = 1'b1;
                            active_next = 1'b0;
                            state_next  = S_IDLE;
                        end
                    end else begin
                        stop_idx_next = stop_idx_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            default: begin
                serial_next = 1'b1;
                active_next = 1'b0;
                baud_next   = '0;
                state_next  = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three character formats run side by side, each
// compared every cycle against a queue-and-timer reference model.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cfg_done = 0;

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level at bit position p of the frame carrying character d
    function automatic logic frame_bit(int d, int p, int db, int par);
        logic x;
        x = 1'b0;
        for (int i = 0; i < db; i++) x = x ^ d[i];
        if (p == 0) return 1'b0;
        if (p <= db) return d[p-1];
        if (par != 0 && p == db + 1) return (par == 2) ? ~x : x;
        return 1'b1;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int DB    = (gi == 0) ? 8 : 7;
        localparam int PAR   = gi;
        localparam int SB    = (gi == 0) ? 1 : 2;
        localparam int CPB   = (gi == 2) ? 3 : 4;
        localparam int DEPTH = 4;
        localparam int NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

        logic rst_n;
        logic active, serial, done;

        uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

        uart_tx_fifo #(
            .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR),
            .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
        ) dut (
            .i_Clock    (clk),
            .i_Rst_n    (rst_n),
            .tx_if      (bus.slave),
            .o_TX_Active(active),
            .o_TX_Serial(serial),
            .o_TX_Done  (done)
        );

        // Reference model: queued characters, and a cycle timer for the frame on the line
        int   m_q[$];
        logic m_busy = 1'b0;
        int   m_cyc  = 0;
        logic m_done = 1'b0;
        int   m_cur  = 0;

        initial begin
            logic wr, end_e, pop, exp_serial;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_q.delete();
                    m_busy = 1'b0;
                    m_cyc  = 0;
                    m_done = 1'b0;
                end else begin
                    wr     = bus.i_TX_DV && (m_q.size() != DEPTH);
                    end_e  = m_busy && (m_cyc == NBITS * CPB - 1);
                    pop    = (m_q.size() != 0) && (!m_busy || end_e);
                    m_done = end_e;
                    if (pop) begin
                        m_cur  = m_q.pop_front();
                        m_busy = 1'b1;
                        m_cyc  = 0;
                    end else if (end_e) begin
                        m_busy = 1'b0;
                    end else if (m_busy) begin
                        m_cyc++;
                    end
                    if (wr) m_q.push_back(int'(bus.i_TX_Byte));
                end
                #1;
                exp_serial = m_busy ? frame_bit(m_cur, m_cyc / CPB, DB, PAR) : 1'b1;
                check_value($sformatf("c%0d.serial", gi), 32'(serial), 32'(exp_serial));
                check_value($sformatf("c%0d.active", gi), 32'(active), 32'(m_busy));
                check_value($sformatf("c%0d.done", gi), 32'(done), 32'(m_done));
                check_value($sformatf("c%0d.count", gi), 32'(bus.o_FIFO_Count), 32'(m_q.size()));
                check_value($sformatf("c%0d.ready", gi), 32'(bus.o_TX_Ready), 32'(m_q.size() != DEPTH));
            end
        end

        // Stimulus: directed frames, fill/overflow, random traffic, mid-frame reset
        initial begin
            rst_n         = 1'b0;
            bus.i_TX_DV   = 1'b0;
            bus.i_TX_Byte = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);

            // single character: 0xA5 on 8N1, 0x35 on the parity formats
            bus.i_TX_DV   = 1'b1;
            bus.i_TX_Byte = DB'((gi == 0) ? 32'hA5 : 32'h35);
            @(negedge clk);
            bus.i_TX_DV = 1'b0;
            repeat (NBITS * CPB + 5) @(negedge clk);

            // six back-to-back writes, the sixth lands on a full FIFO
            for (int k = 1; k <= 6; k++) begin
                bus.i_TX_DV   = 1'b1;
                bus.i_TX_Byte = DB'(k);
                @(negedge clk);
            end
            bus.i_TX_DV = 1'b0;
            repeat (6 * NBITS * CPB + 5) @(negedge clk);

            // random traffic: heavy then sparse
            for (int k = 0; k < 1500; k++) begin
                bus.i_TX_DV   = ($urandom_range(0, (k < 750) ? 2 : 40) == 0);
                bus.i_TX_Byte = DB'($urandom);
                @(negedge clk);
            end
            bus.i_TX_DV = 1'b0;
            repeat (5 * NBITS * CPB + 5) @(negedge clk);

            // fill to full, then hold the strobe three more cycles
            for (int k = 0; k < 8; k++) begin
                bus.i_TX_DV   = 1'b1;
                bus.i_TX_Byte = DB'(32'h10 + k);
                @(negedge clk);
            end
            bus.i_TX_DV = 1'b0;
            repeat (5 * NBITS * CPB + 5) @(negedge clk);

            // reset during data bit 3 with two characters queued
            for (int k = 0; k < 3; k++) begin
                bus.i_TX_DV   = 1'b1;
                bus.i_TX_Byte = DB'(32'h2A + k);
                @(negedge clk);
            end
            bus.i_TX_DV = 1'b0;
            repeat (4 * CPB) @(negedge clk);
            #2 rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (3 * NBITS * CPB) @(negedge clk);

            cfg_done++;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (cfg_done == 3) break;
        end
        check_value("all_done", 32'(cfg_done), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
